// File: rtl/seg_bcd_scanner.sv
// seg_bcd_scanner: converts a binary value to decimal (double dabble) or hex digits
// and drives a time-multiplexed 7-segment display with leading-zero blanking and overflow dashes.
module seg_bcd_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DATA_W       = 16,
    parameter int REFRESH_BITS = 18,
    parameter bit ACTIVE_LOW   = 1
) (
    input  logic                  clk_100mhz,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  ovf,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(DATA_W);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_POL = ACTIVE_LOW ? 7'b0000000 : 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] AN_POL = ACTIVE_LOW ? '0 : '1;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [63:0] dec_max(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] DEC_MAX = dec_max(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                  state, state_nx;
    logic [DATA_W-1:0]       sh;
    logic [DW-1:0]           bcd, adj, disp;
    logic [CW-1:0]           cnt;
    logic                    mode_r, mode_c, ovf_p;
    logic [REFRESH_BITS-1:0] ref_cnt;
    logic [IW-1:0]           idx;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    nz;
    logic [3:0]              cur;
    logic [6:0]              seg_nx;

    assign busy = state != IDLE;

    always_ff @(posedge clk_100mhz or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = load ? CONVERT : IDLE;
            CONVERT: state_nx = (mode_r || cnt == CW'(DATA_W - 1)) ? COMMIT : CONVERT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Overflow is decided at capture and only becomes visible at commit.
    always_ff @(posedge clk_100mhz or posedge reset)
        if (reset) begin
            sh     <= '0;
            bcd    <= '0;
            cnt    <= '0;
            mode_r <= 1'b0;
            ovf_p  <= 1'b0;
            disp   <= '0;
            mode_c <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (state == IDLE && load) begin
                sh     <= data_in;
                bcd    <= '0;
                cnt    <= '0;
                mode_r <= hex_mode;
                ovf_p  <= hex_mode ? (64'(data_in) >> DW) != 64'd0 : 64'(data_in) > DEC_MAX;
            end
            if (state == CONVERT) begin
                sh  <= sh << 1;
                cnt <= cnt + 1'b1;
                bcd <= mode_r ? DW'(sh) : {adj[DW-2:0], sh[DATA_W-1]};
            end
            if (state == COMMIT) begin
                disp   <= bcd;
                mode_c <= mode_r;
                ovf    <= ovf_p;
            end
        end

    always_comb begin
        nz    = 1'b0;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            nz       = nz | (disp[4*i +: 4] != 4'd0);
            blank[i] = blank_lz && !nz;
        end
    end

    assign cur    = disp[idx*4 +: 4];
    assign seg_nx = ovf ? SEG_DASH :
                    (blank[idx] || (!mode_c && cur > 4'd9)) ? SEG_BLANK : SEG_LUT[cur];

    always_ff @(posedge clk_100mhz or posedge reset)
        if (reset) begin
            ref_cnt <= '0;
            idx     <= '0;
            anode   <= ~NUM_DIGITS'(1) ^ AN_POL;
            seg     <= SEG_LUT[0] ^ SEG_POL;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
            if (&ref_cnt) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            anode   <= ~(NUM_DIGITS'(1) << idx) ^ AN_POL;
            seg     <= seg_nx ^ SEG_POL;
        end
endmodule

// File: tb/tb_seg_bcd_scanner.sv
// tb_seg_bcd_scanner: scoreboard bench; stimulus queues expected busy length, ovf and
// per-digit segments, a monitor checks them whenever a conversion finishes.
module tb_seg_bcd_scanner;
    logic        clk_100mhz = 1'b0, reset = 1'b1, load = 1'b0, hex_mode = 1'b0, blank_lz = 1'b0;
    logic [15:0] data_in = '0;
    logic        busy, ovf, busy3, ovf3;
    logic [3:0]  anode;
    logic [2:0]  anode3;
    logic [6:0]  seg, seg3;
    int          checks = 0, failures = 0;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S7 = 7'b0001111, S9 = 7'b0000100;
    localparam logic [6:0] S_A = 7'b0001000, S_LB = 7'b1100000, S_E = 7'b0110000, S_F = 7'b0111000;
    localparam logic [6:0] S_DASH = 7'b1111110, S_BLK = 7'b1111111;

    typedef struct {
        string           name;
        int              nbusy;
        logic            ovf;
        logic [3:0][6:0] segs;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] want3 [4] = '{3'b110, 3'b101, 3'b011, 3'b110};

    always #5 clk_100mhz = ~clk_100mhz;

    seg_bcd_scanner #(.NUM_DIGITS(4), .DATA_W(16), .REFRESH_BITS(4), .ACTIVE_LOW(1)) dut (
        .clk_100mhz(clk_100mhz), .reset(reset), .data_in(data_in), .load(load),
        .hex_mode(hex_mode), .blank_lz(blank_lz), .busy(busy), .ovf(ovf),
        .anode(anode), .seg(seg)
    );

    seg_bcd_scanner #(.NUM_DIGITS(3), .DATA_W(16), .REFRESH_BITS(4), .ACTIVE_LOW(1)) dut3 (
        .clk_100mhz(clk_100mhz), .reset(reset), .data_in(16'd0), .load(1'b0),
        .hex_mode(1'b0), .blank_lz(1'b0), .busy(busy3), .ovf(ovf3),
        .anode(anode3), .seg(seg3)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic issue(input logic [15:0] d, input logic hx);
        @(negedge clk_100mhz);
        data_in  = d;
        hex_mode = hx;
        load     = 1'b1;
        @(negedge clk_100mhz);
        load = 1'b0;
    endtask

    task automatic expect_txn(input string nm, input int nb, input logic ov,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        exp_t e;
        e.name  = nm;
        e.nbusy = nb;
        e.ovf   = ov;
        e.segs  = {s3, s2, s1, s0};
        sb.push_back(e);
    endtask

    task automatic settle();
        int n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk_100mhz);
        end
        check("idle_timeout", 32'(n < 100), 1);
        repeat (160) @(negedge clk_100mhz);
    endtask

    task automatic run_txn(input string nm, input logic [15:0] d, input logic hx, input logic bl,
                           input int nb, input logic ov, input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0);
        blank_lz = bl;
        expect_txn(nm, nb, ov, s3, s2, s1, s0);
        issue(d, hx);
        settle();
    endtask

    initial begin : monitor
        exp_t e;
        int   n, w;
        forever begin
            @(negedge clk_100mhz);
            if (busy) begin
                n = 0;
                while (busy && n < 200) begin
                    n++;
                    @(negedge clk_100mhz);
                end
                if (sb.size() == 0) check("unexpected_txn", 1, 0);
                else begin
                    e = sb.pop_front();
                    check({e.name, "_busy"}, n, e.nbusy);
                    repeat (2) @(negedge clk_100mhz);
                    check({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
                    for (int k = 0; k < 4; k++) begin
                        w = 0;
                        while (anode !== ~(4'b0001 << k) && w < 200) begin
                            w++;
                            @(negedge clk_100mhz);
                        end
                        check($sformatf("%s_scan%0d", e.name, k), 32'(w < 200), 1);
                        check($sformatf("%s_dig%0d", e.name, k), 32'(seg), 32'(e.segs[k]));
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [2:0] cur3;
        int         step, run, bad, n;
        repeat (3) @(negedge clk_100mhz);
        reset = 1'b0;
        @(negedge clk_100mhz);
        check("rst_anode", 32'(anode), 32'(4'b1110));
        check("rst_seg", 32'(seg), 32'(S0));
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("nd3_first", 32'(anode3), 32'(3'b110));
        cur3 = anode3;
        step = 0;
        run  = 1;
        bad  = 0;
        n    = 0;
        while (step < 3 && n < 100) begin
            @(negedge clk_100mhz);
            n++;
            if (!$onehot(~anode3)) bad++;
            if (anode3 == cur3) run++;
            else begin
                step++;
                if (step > 1) check($sformatf("nd3_dwell%0d", step - 1), run, 16);
                check($sformatf("nd3_step%0d", step), 32'(anode3), 32'(want3[step]));
                cur3 = anode3;
                run  = 1;
            end
        end
        check("nd3_onehot", bad, 0);
        check("nd3_done", step, 3);

        run_txn("d1234",   16'd1234,  1'b0, 1'b0, 17, 1'b0, S1, S2, S3, S4);
        run_txn("d12345",  16'd12345, 1'b0, 1'b0, 17, 1'b1, S_DASH, S_DASH, S_DASH, S_DASH);
        run_txn("hBEEF",   16'hBEEF,  1'b1, 1'b0, 2,  1'b0, S_LB, S_E, S_E, S_F);
        run_txn("d7blank", 16'd7,     1'b0, 1'b1, 17, 1'b0, S_BLK, S_BLK, S_BLK, S7);
        run_txn("d7",      16'd7,     1'b0, 1'b0, 17, 1'b0, S0, S0, S0, S7);
        run_txn("d9999",   16'd9999,  1'b0, 1'b0, 17, 1'b0, S9, S9, S9, S9);
        run_txn("d10000",  16'd10000, 1'b0, 1'b1, 17, 1'b1, S_DASH, S_DASH, S_DASH, S_DASH);
        run_txn("d0blank", 16'd0,     1'b0, 1'b1, 17, 1'b0, S_BLK, S_BLK, S_BLK, S0);
        run_txn("hA05",    16'h0A05,  1'b1, 1'b1, 2,  1'b0, S_BLK, S_A, S0, S5);

        blank_lz = 1'b0;
        expect_txn("d42", 17, 1'b0, S0, S0, S4, S2);
        issue(16'd42, 1'b0);
        repeat (3) @(negedge clk_100mhz);
        issue(16'd99, 1'b0);
        settle();

        expect_txn("abort", 5, 1'b0, S0, S0, S0, S0);
        issue(16'd1234, 1'b0);
        repeat (5) @(posedge clk_100mhz);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_anode", 32'(anode), 32'(4'b1110));
        check("abort_seg", 32'(seg), 32'(S0));
        repeat (3) @(negedge clk_100mhz);
        reset = 1'b0;
        settle();

        run_txn("d305", 16'd305, 1'b0, 1'b0, 17, 1'b0, S0, S3, S0, S5);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
